// File: rtl/program_loader.sv
// Serial nibble loader: assembles instruction words from a nibble stream
// and writes them into instruction memory while holding the CPU.
module program_loader #(
  parameter int NIBS   = 4,
  parameter int ADDR_W = 4
) (
  input  logic                CLK,
  input  logic                RESET,
  input  logic                Start,
  input  logic [ADDR_W-1:0]   Count,
  input  logic                Abort,
  input  logic [3:0]          NibIn,
  input  logic                NibValid,
  output logic                NibReady,
  output logic                IMemWE,
  output logic [ADDR_W-1:0]   IMemAddr,
  output logic [4*NIBS-1:0]   IMemData,
  output logic                CpuHold,
  output logic                Done
);

  localparam int DW = 4 * NIBS;
  localparam int NW = $clog2(NIBS + 1);
  localparam int WW = ADDR_W + 1;
  localparam logic [NW-1:0] NLAST = NW'(NIBS - 1);
  localparam logic [WW-1:0] FULL = WW'(1) << ADDR_W;

  typedef enum logic [1:0] {
    IDLE,
    COLLECT,
    WRITE,
    DONE
  } state_t;

  state_t            st;
  state_t            nxt;
  logic [ADDR_W-1:0] addr;
  logic [ADDR_W-1:0] cnt_lat;
  logic [NW-1:0]     nib_cnt;
  logic [WW-1:0]     word_cnt;
  logic [DW-1:0]     shreg;
  logic [WW-1:0]     target;
  logic              accept;
  logic              last_nib;
  logic              last_word;

  // A latched Count of zero means a full memory image.
  assign target    = (cnt_lat == '0) ? FULL : {1'b0, cnt_lat};
  assign accept    = (st == COLLECT) && NibValid;
  assign last_nib  = (nib_cnt == NLAST);
  assign last_word = (word_cnt == target);

  always_comb begin
    nxt = st;
    unique case (st)
      IDLE: begin
        if (Start && !Abort) nxt = COLLECT;
      end
      COLLECT: begin
        if (Abort) nxt = IDLE;
        else if (accept && last_nib) nxt = WRITE;
      end
      WRITE: begin
        if (Abort) nxt = IDLE;
        else if (last_word) nxt = DONE;
        else nxt = COLLECT;
      end
      DONE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      st       <= IDLE;
      addr     <= '0;
      cnt_lat  <= '0;
      nib_cnt  <= '0;
      word_cnt <= '0;
      shreg    <= '0;
    end else begin
      st <= nxt;
      unique case (st)
        IDLE: begin
          if (Start && !Abort) begin
            cnt_lat  <= Count;
            addr     <= '0;
            nib_cnt  <= '0;
            word_cnt <= '0;
            shreg    <= '0;
          end
        end
        COLLECT: begin
          if (accept && !Abort) begin
            shreg   <= (shreg << 4) | DW'(NibIn);
            nib_cnt <= nib_cnt + NW'(1);
            if (last_nib) word_cnt <= word_cnt + WW'(1);
          end
        end
        WRITE: begin
          if (!Abort && !last_word) begin
            addr    <= addr + ADDR_W'(1);
            nib_cnt <= '0;
          end
        end
        default: ;
      endcase
    end
  end

  assign NibReady = (st == COLLECT);
  assign IMemWE   = (st == WRITE);
  assign CpuHold  = (st != IDLE);
  assign Done     = (st == DONE);
  assign IMemAddr = addr;
  assign IMemData = shreg;

endmodule

// File: tb/tb_program_loader.sv
// Scoreboard bench for program_loader: directed loads, gaps, reset,
// abort and start-during-load cases.
module tb_program_loader;

  logic        CLK = 0;
  logic        RESET = 1;
  logic        Start = 0;
  logic [3:0]  Count = 0;
  logic        Abort = 0;
  logic [3:0]  NibIn = 0;
  logic        NibValid = 0;
  logic        NibReady;
  logic        IMemWE;
  logic [3:0]  IMemAddr;
  logic [15:0] IMemData;
  logic        CpuHold;
  logic        Done;

  program_loader #(.NIBS(4), .ADDR_W(4)) dut (
    .CLK(CLK), .RESET(RESET), .Start(Start), .Count(Count),
    .Abort(Abort), .NibIn(NibIn), .NibValid(NibValid),
    .NibReady(NibReady), .IMemWE(IMemWE), .IMemAddr(IMemAddr),
    .IMemData(IMemData), .CpuHold(CpuHold), .Done(Done)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    bit          is_done;
    logic [3:0]  addr;
    logic [15:0] data;
  } ev_t;

  ev_t sb[$];
  int  checks = 0;
  int  errors = 0;
  int  acc = 0;
  int  nwr = 0;
  int  ndone = 0;
  bit  last_we = 0;

  // Monitor: pops expected events whenever the DUT writes or signals done.
  always @(negedge CLK) begin
    ev_t e;
    if (!RESET) begin
      if (NibValid && NibReady) acc++;
      if (IMemWE) begin
        nwr++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL write_unexpected got addr=%0h data=%04h required none",
                   IMemAddr, IMemData);
        end else begin
          e = sb.pop_front();
          if (e.is_done || e.addr !== IMemAddr || e.data !== IMemData) begin
            errors++;
            $display("FAIL write got addr=%0h data=%04h required done=%0d addr=%0h data=%04h",
                     IMemAddr, IMemData, e.is_done, e.addr, e.data);
          end
        end
      end
      if (Done) begin
        ndone++;
        checks++;
        if (sb.size() == 0) begin
          errors++;
          $display("FAIL done_unexpected got Done=1 required none");
        end else begin
          e = sb.pop_front();
          if (!e.is_done) begin
            errors++;
            $display("FAIL done_order got Done=1 required write addr=%0h data=%04h",
                     e.addr, e.data);
          end
        end
        checks++;
        if (!last_we) begin
          errors++;
          $display("FAIL done_timing got prev_we=0 required prev_we=1");
        end
      end
    end
    last_we = IMemWE;
  end

  task automatic chk(input string name, input logic [31:0] got,
                     input logic [31:0] req);
    checks++;
    if (got !== req) begin
      errors++;
      $display("FAIL %s got %0h required %0h", name, got, req);
    end
  endtask

  task automatic push_w(input logic [3:0] a, input logic [15:0] d);
    ev_t e;
    e.is_done = 0;
    e.addr = a;
    e.data = d;
    sb.push_back(e);
  endtask

  task automatic push_d();
    ev_t e;
    e.is_done = 1;
    e.addr = 0;
    e.data = 0;
    sb.push_back(e);
  endtask

  task automatic start_load(input logic [3:0] c);
    @(posedge CLK); #1;
    Count = c;
    Start = 1;
    @(posedge CLK); #1;
    Start = 0;
  endtask

  task automatic send_nib(input logic [3:0] n);
    bit ok;
    ok = 0;
    NibIn = n;
    NibValid = 1;
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (NibReady) begin
        ok = 1;
        break;
      end
    end
    @(posedge CLK); #1;
    NibValid = 0;
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL nib_timeout got NibReady=0 required 1");
    end
  endtask

  task automatic send_word(input logic [15:0] w, input bit gap);
    for (int k = 3; k >= 0; k--) begin
      send_nib(w[k*4 +: 4]);
      if (gap) begin
        @(posedge CLK); #1;
      end
    end
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 50; i++) begin
      @(negedge CLK);
      if (!CpuHold) break;
    end
    chk("cpuhold_idle", 32'(CpuHold), 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout got running required finished");
    $fatal(1, "timeout");
  end

  initial begin
    int a0;
    int w0;
    logic [15:0] d;

    repeat (2) @(posedge CLK);
    #1 RESET = 0;
    @(negedge CLK);
    chk("rst_nibready", 32'(NibReady), 0);
    chk("rst_we", 32'(IMemWE), 0);
    chk("rst_addr", 32'(IMemAddr), 0);
    chk("rst_data", 32'(IMemData), 0);
    chk("rst_hold", 32'(CpuHold), 0);
    chk("rst_done", 32'(Done), 0);

    // Single word, continuous valid
    push_w(0, 16'h84A1);
    push_d();
    start_load(1);
    chk("hold_collect", 32'(CpuHold), 1);
    send_word(16'h84A1, 0);
    wait_idle();

    // Two words, second with gapped valid
    a0 = acc;
    push_w(0, 16'h84A1);
    push_w(1, 16'h00F3);
    push_d();
    start_load(2);
    send_word(16'h84A1, 0);
    send_word(16'h00F3, 1);
    wait_idle();
    @(posedge CLK); #1;
    NibValid = 1;
    NibIn = 4'h7;
    repeat (3) @(posedge CLK);
    #1 NibValid = 0;
    chk("nib_count_2w", 32'(acc - a0), 8);

    // Full 16-word image
    w0 = nwr;
    for (int i = 0; i < 16; i++) begin
      d = {4'(i), ~4'(i), 4'(i) ^ 4'h5, 4'hC};
      push_w(4'(i), d);
    end
    push_d();
    start_load(0);
    for (int i = 0; i < 16; i++) begin
      d = {4'(i), ~4'(i), 4'(i) ^ 4'h5, 4'hC};
      send_word(d, 0);
    end
    wait_idle();
    repeat (3) @(negedge CLK);
    chk("writes_16", 32'(nwr - w0), 16);

    // Reset mid-word
    start_load(1);
    send_nib(4'hF);
    send_nib(4'hE);
    RESET = 1;
    @(posedge CLK); #1;
    RESET = 0;
    @(negedge CLK);
    chk("mrst_nibready", 32'(NibReady), 0);
    chk("mrst_hold", 32'(CpuHold), 0);
    chk("mrst_data", 32'(IMemData), 0);
    chk("mrst_we", 32'(IMemWE), 0);
    push_w(0, 16'h1234);
    push_d();
    start_load(1);
    send_word(16'h1234, 0);
    wait_idle();

    // Abort during WRITE of word 1
    w0 = ndone;
    push_w(0, 16'hAAAA);
    push_w(1, 16'hBBBB);
    start_load(3);
    send_word(16'hAAAA, 0);
    send_word(16'hBBBB, 0);
    Abort = 1;
    @(posedge CLK); #1;
    Abort = 0;
    @(negedge CLK);
    chk("abort_idle", 32'(CpuHold), 0);
    repeat (4) @(negedge CLK);
    chk("abort_nodone", 32'(ndone - w0), 0);

    // Start pulsed mid-word must not restart the load
    push_w(0, 16'hCAFE);
    push_w(1, 16'h5678);
    push_d();
    start_load(2);
    send_word(16'hCAFE, 0);
    send_nib(4'h5);
    send_nib(4'h6);
    Count = 4'h5;
    Start = 1;
    @(posedge CLK); #1;
    Start = 0;
    send_nib(4'h7);
    send_nib(4'h8);
    wait_idle();

    // Abort and Start together in IDLE
    @(posedge CLK); #1;
    Start = 1;
    Abort = 1;
    @(posedge CLK); #1;
    Start = 0;
    Abort = 0;
    @(negedge CLK);
    chk("abort_start_idle", 32'(CpuHold), 0);

    repeat (3) @(negedge CLK);
    chk("sb_empty", 32'(sb.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/program_loader.md
PROGRAM_LOADER -- requirements
Module: program_loader

Interface
REQ-001 SHALL have parameter NIBS, default 4, the number of 4-bit nibbles per instruction word; the word width is 4*NIBS.
REQ-002 SHALL have parameter ADDR_W, default 4, the instruction-memory address width (16 words).
REQ-003 SHALL have port CLK  in  1  system clock; all state changes on rising edge.
REQ-004 SHALL have port RESET  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port Start  in  1  level request to begin a load; sampled only in IDLE.
REQ-006 SHALL have port Count  in  ADDR_W  number of words to load; 0 means 2^ADDR_W.
REQ-007 SHALL have port Abort  in  1  terminate the load, return to IDLE.
REQ-008 SHALL have port NibIn  in  4  serial nibble data, MSB nibble first.
REQ-009 SHALL have port NibValid  in  1  source asserts when NibIn is valid.
REQ-010 SHALL have port NibReady  out  1  loader accepts a nibble this cycle.
REQ-011 SHALL have port IMemWE  out  1  instruction-memory write enable.
REQ-012 SHALL have port IMemAddr  out  ADDR_W  instruction-memory write address.
REQ-013 SHALL have port IMemData  out  4*NIBS  instruction-memory write data.
REQ-014 SHALL have port CpuHold  out  1  holds the control unit's PC and register writes while loading.
REQ-015 SHALL have port Done  out  1  one-cycle pulse when the load completes.

Function
REQ-016 SHALL implement states IDLE, COLLECT, WRITE and DONE, with all outputs decoded from state and registers (Moore).
REQ-017 SHALL, in IDLE with Start=1, latch Count, clear the address, nibble and word counters, and enter COLLECT on the next edge.
REQ-018 SHALL drive CpuHold=1 in COLLECT, WRITE and DONE, and CpuHold=0 in IDLE.
REQ-019 SHALL drive NibReady=1 only in COLLECT.
REQ-020 SHALL accept a nibble only on an edge where NibValid=1 and NibReady=1, then shift it in (shift register <= {shift register[4*NIBS-5:0], NibIn}).
REQ-021 SHALL hold the shift register and nibble counter unchanged in COLLECT while NibValid=0.
REQ-022 SHALL move COLLECT to WRITE on the edge that accepts the NIBS-th nibble.
REQ-023 SHALL, in WRITE, last exactly one cycle and drive IMemWE=1, IMemAddr=current address and IMemData=the shift register.
REQ-024 SHALL drive IMemWE=0 in every state other than WRITE.
REQ-025 SHALL, leaving WRITE: go to DONE if the word counter equals the latched Count (0 counts as 2^ADDR_W); otherwise increment the address, clear the nibble counter and return to COLLECT.
REQ-026 SHALL drive Done=1 in DONE for exactly one cycle, then return to IDLE.
REQ-027 SHALL have a latency of one cycle from acceptance of the last nibble of a word to IMemWE=1, and NibReady=1 again on the cycle after the WRITE cycle.
REQ-028 SHALL wrap the address modulo 2^ADDR_W internally and never write beyond Count words.
REQ-029 SHALL ignore Start outside IDLE.
REQ-030 SHALL ignore Start on the DONE-to-IDLE edge; a new load requires Start sampled in IDLE.
REQ-031 SHALL, on Abort=1 in COLLECT, WRITE or DONE, go to IDLE on the next edge without pulsing Done, discard any partial word, and still complete a write already being presented in the current WRITE cycle.
REQ-032 SHALL give Abort priority over all other transitions, and give RESET priority over Abort.
REQ-033 SHALL, when Abort and Start are both 1 in IDLE, stay in IDLE.

Reset
REQ-034 SHALL, on RESET=1 at a rising edge in any state including mid-word, enter IDLE and clear the address, nibble counter, word counter, shift register and latched Count.
REQ-035 SHALL, after reset, drive NibReady=0, IMemWE=0, IMemAddr=0, IMemData=0, CpuHold=0 and Done=0.
REQ-036 SHALL have no reset state that drives IMemWE=1.

Verification
REQ-037 SHALL be verified by: Count=1, nibbles 8,4,A,1 with NibValid held high -> IMemWE one cycle, Addr=0, Data=0x84A1, Done pulse one cycle later, CpuHold low after.
REQ-038 SHALL be verified by: Count=2, second word nibbles 0,0,F,3 with NibValid gapped every other cycle -> writes 0x84A1@0 and 0x00F3@1, no extra nibbles accepted.
REQ-039 SHALL be verified by: Count=0 with 16 words -> 16 writes at Addr 0..15, Done once, no write at 16/wrap.
REQ-040 SHALL be verified by: RESET after 2 nibbles of word 0 -> all outputs at reset values next cycle, and a subsequent load stores only the new nibbles.
REQ-041 SHALL be verified by: Abort during the WRITE of word 1 of a Count=3 load -> word 1 written, no word 2, Done stays 0, IDLE next cycle.
REQ-042 SHALL be verified by: Start pulsed during COLLECT -> no restart; address continues unchanged.
